// File: rtl/blimp_test_mem_responder.sv
// ----------------------------------------------------------------------------
// blimp_test_mem_responder
//
// Server end of the Blimp memory request/response interface. Answers 32-bit
// word reads and writes from a fetch or load/store client with a fixed
// pipeline latency, then queues responses in an in-order FIFO. The number of
// outstanding requests (pipeline + FIFO) is credit-limited so a response is
// never dropped; req_rdy falls when the credits run out.
//
// Parameters
//   p_opaq_bits   width of the opaque tag echoed from request to response
//   p_mem_words   word-addressed storage depth (power of two, >= 2)
//   p_latency     cycles from request fire to earliest resp_val (>= 1)
//   p_resp_depth  maximum outstanding requests (>= 1)
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   req_val/rdy   request handshake
//   req_op        0 = read, 1 = write
//   req_opaque    client tag
//   req_addr      byte address, bits [1:0] ignored, wraps modulo memory size
//   req_data      write data
//   resp_val/rdy  response handshake
//   resp_op/opaque/addr  echoes of the request
//   resp_data     read data, 0 for writes
// ----------------------------------------------------------------------------
module blimp_test_mem_responder #(
    parameter int p_opaq_bits  = 8,
    parameter int p_mem_words  = 1024,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic                   req_op,
    input  logic [p_opaq_bits-1:0] req_opaque,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_data,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_op,
    output logic [p_opaq_bits-1:0] resp_opaque,
    output logic [31:0]            resp_addr,
    output logic [31:0]            resp_data
);

    localparam int AW = $clog2(p_mem_words);
    localparam int PW = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
    localparam int CW = $clog2(p_resp_depth + 1);

    typedef struct packed {
        logic                   op;
        logic [p_opaq_bits-1:0] opaque;
        logic [31:0]            addr;
        logic [31:0]            data;
    } entry_t;

    // Storage (intentionally never reset)
    logic [31:0]   mem_q [p_mem_words];
    logic [AW-1:0] req_idx;

    logic   req_fire;
    logic   resp_fire;
    entry_t req_entry;

    // Latency pipeline
    entry_t               stg_q [p_latency];
    logic [p_latency-1:0] stg_vld_q;

    // Response FIFO and credit counter
    entry_t        fifo_q [p_resp_depth];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          enq;
    entry_t        head;

    // Pointers wrap modulo depth, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(p_resp_depth - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Backdoor storage access for bench preload and checking.
    task automatic load_word(input logic [AW-1:0] idx, input logic [31:0] data);
        mem_q[idx] <= data;
    endtask

    function automatic logic [31:0] read_word(input logic [AW-1:0] idx);
        return mem_q[idx];
    endfunction

    assign req_idx   = req_addr[2 +: AW];
    // Ready depends only on the registered credit count, never on resp_rdy.
    assign req_rdy   = !rst && (out_cnt_q < CW'(p_resp_depth));
    assign req_fire  = req_val && req_rdy;
    assign resp_val  = (fifo_cnt_q != '0);
    assign resp_fire = resp_val && resp_rdy;
    assign enq       = stg_vld_q[p_latency-1];

    // Read data is taken from storage before this edge's write lands; earlier
    // writes have already been committed, so reads see them.
    always_comb begin
        req_entry.op     = req_op;
        req_entry.opaque = req_opaque;
        req_entry.addr   = req_addr;
        req_entry.data   = req_op ? 32'h0 : mem_q[req_idx];
    end

    always_ff @(posedge clk) begin
        if (req_fire && req_op) begin
            mem_q[req_idx] <= req_data;
        end
    end

    // Stage 0 captures at the fire edge; the last stage feeds the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld_q <= '0;
        end else begin
            stg_vld_q[0] <= req_fire;
            for (int k = 1; k < p_latency; k++) begin
                stg_vld_q[k] <= stg_vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stg_q[0] <= req_entry;
        for (int k = 1; k < p_latency; k++) begin
            stg_q[k] <= stg_q[k-1];
        end
    end

    // FIFO / credit next-state
    always_comb begin
        wr_ptr_d   = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = resp_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (enq && !resp_fire) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (!enq && resp_fire) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
        out_cnt_d = out_cnt_q;
        if (req_fire && !resp_fire) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!req_fire && resp_fire) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    // Credits bound occupancy, so an enqueue always has a free slot.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[wr_ptr_q] <= stg_q[p_latency-1];
        end
    end

    // Payload is held at zero whenever no response is presented (incl. reset).
    assign head        = fifo_q[rd_ptr_q];
    assign resp_op     = resp_val ? head.op     : 1'b0;
    assign resp_opaque = resp_val ? head.opaque : '0;
    assign resp_addr   = resp_val ? head.addr   : 32'h0;
    assign resp_data   = resp_val ? head.data   : 32'h0;

endmodule

// File: tb/tb_blimp_test_mem_responder.sv
module tb_blimp_test_mem_responder;

    localparam int OPQ   = 8;
    localparam int WORDS = 1024;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int AWB   = $clog2(WORDS);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic        req_op = 1'b0;
    logic [7:0]  req_opaque = 8'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic        resp_val;
    logic        resp_rdy = 1'b1;
    logic        resp_op;
    logic [7:0]  resp_opaque;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;

    blimp_test_mem_responder #(
        .p_opaq_bits (OPQ),
        .p_mem_words (WORDS),
        .p_latency   (LAT),
        .p_resp_depth(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_op     (req_op),
        .req_opaque (req_opaque),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_op    (resp_op),
        .resp_opaque(resp_opaque),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word array plus an in-order queue of expected
    // responses, each with the cycle from which it may be presented.
    typedef struct {
        logic        op;
        logic [7:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
        int          ready;
    } exp_t;

    typedef struct {
        logic        op;
        logic [7:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic [31:0] mmem [WORDS];
    exp_t        exp_q[$];
    rsp_t        log_q[$];
    int          dut_req_fires  = 0;
    int          dut_resp_fires = 0;

    function automatic rsp_t log_at(input int i);
        rsp_t r;
        r.op = 1'b0; r.tag = 8'h0; r.addr = 32'h0; r.data = 32'h0; r.cyc = -1;
        if (i >= 0 && i < log_q.size()) r = log_q[i];
        return r;
    endfunction

    // Compare process: sampled mid-cycle, then advances the model by the
    // handshakes that will complete at the coming rising edge.
    always @(negedge clk) begin : monitor
        bit   m_rdy;
        bit   m_val;
        exp_t e;
        rsp_t r;
        int   idx;
        if (chk_en) begin
            if (rst) begin
                chk("rst_req_rdy",     32'(req_rdy),     32'h0);
                chk("rst_resp_val",    32'(resp_val),    32'h0);
                chk("rst_resp_op",     32'(resp_op),     32'h0);
                chk("rst_resp_opaque", 32'(resp_opaque), 32'h0);
                chk("rst_resp_addr",   resp_addr,        32'h0);
                chk("rst_resp_data",   resp_data,        32'h0);
                exp_q.delete();
            end else begin
                m_rdy = (exp_q.size() < DEPTH);
                m_val = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
                chk("req_rdy",  32'(req_rdy),  32'(m_rdy));
                chk("resp_val", 32'(resp_val), 32'(m_val));
                if (m_val) begin
                    chk("resp_op",     32'(resp_op),     32'(exp_q[0].op));
                    chk("resp_opaque", 32'(resp_opaque), 32'(exp_q[0].tag));
                    chk("resp_addr",   resp_addr,        exp_q[0].addr);
                    chk("resp_data",   resp_data,        exp_q[0].data);
                end
                if (resp_val && resp_rdy) begin
                    r.op = resp_op; r.tag = resp_opaque; r.addr = resp_addr;
                    r.data = resp_data; r.cyc = cyc + 1;
                    log_q.push_back(r);
                    dut_resp_fires++;
                end
                if (req_val && req_rdy) dut_req_fires++;
                if (m_val && resp_rdy) exp_q.delete(0);
                if (req_val && m_rdy) begin
                    idx    = int'(req_addr[2 +: AWB]);
                    e.op   = req_op;
                    e.tag  = req_opaque;
                    e.addr = req_addr;
                    e.data = req_op ? 32'h0 : mmem[idx];
                    e.ready = cyc + 1 + LAT;
                    if (req_op) mmem[idx] = req_data;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic op, input logic [7:0] tag, input logic [31:0] addr,
                         input logic [31:0] data);
        bit fired;
        fired = 1'b0;
        req_val = 1'b1; req_op = op; req_opaque = tag; req_addr = addr; req_data = data;
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clk);
            fired = req_rdy;
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
        if (!fired) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: tag=0x%02h never accepted", tag);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : driver
        int          base_log;
        int          base_rf;
        int          t0;
        rsp_t        r;
        logic [31:0] v;
        logic [31:0] a;

        // Reset with a request pending
        rst = 1'b1; req_val = 1'b1; resp_rdy = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom();
            dut.load_word(AWB'(i), v);
            mmem[i] = v;
        end
        @(negedge clk);
        chk("t1_rdy_in_reset", 32'(req_rdy), 32'h0);
        chk("t1_val_in_reset", 32'(resp_val), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_val = 1'b0;
        @(negedge clk);
        chk("t1_rdy_after_reset", 32'(req_rdy), 32'h1);
        @(posedge clk); #1;

        // Preloaded read and latency
        dut.load_word(AWB'(3), 32'hDEADBEEF);
        mmem[3] = 32'hDEADBEEF;
        issue(1'b0, 8'h5A, 32'h0000_000C, 32'h0);
        @(negedge clk);
        chk("t2_val_after_N", 32'(resp_val), 32'h0);
        @(negedge clk);
        chk("t2_val_after_N1", 32'(resp_val), 32'h0);
        @(negedge clk);
        chk("t2_val_after_N2", 32'(resp_val), 32'h1);
        chk("t2_data",   resp_data,        32'hDEADBEEF);
        chk("t2_opaque", 32'(resp_opaque), 32'h5A);
        chk("t2_op",     32'(resp_op),     32'h0);
        @(posedge clk); #1;
        idle(3);

        // Write then read the same word
        base_log = log_q.size();
        issue(1'b1, 8'h01, 32'h10, 32'h1234);
        issue(1'b0, 8'h02, 32'h10, 32'h0);
        idle(6);
        chk("t3_count", 32'(log_q.size() - base_log), 32'd2);
        r = log_at(base_log);
        chk("t3_wr_op", 32'(r.op), 32'h1);
        chk("t3_wr_tag", 32'(r.tag), 32'h01);
        chk("t3_wr_data", r.data, 32'h0);
        r = log_at(base_log + 1);
        chk("t3_rd_op", 32'(r.op), 32'h0);
        chk("t3_rd_tag", 32'(r.tag), 32'h02);
        chk("t3_rd_data", r.data, 32'h1234);

        // Credit limit under back-pressure
        base_log = log_q.size();
        base_rf  = dut_req_fires;
        resp_rdy = 1'b0;
        for (int k = 0; k < 4; k++) issue(1'b0, 8'(8'h40 + k), 32'(k * 4), 32'h0);
        req_val = 1'b1; req_op = 1'b0; req_opaque = 8'h44; req_addr = 32'h10; req_data = 32'h0;
        idle(6);
        @(negedge clk);
        chk("t4_fired", 32'(dut_req_fires - base_rf), 32'd4);
        chk("t4_rdy_low", 32'(req_rdy), 32'h0);
        chk("t4_val_held", 32'(resp_val), 32'h1);
        chk("t4_head_tag", 32'(resp_opaque), 32'h40);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        issue(1'b0, 8'h44, 32'h10, 32'h0);
        issue(1'b0, 8'h45, 32'h14, 32'h0);
        idle(8);
        chk("t4_count", 32'(log_q.size() - base_log), 32'd6);
        for (int k = 0; k < 6; k++) begin
            r = log_at(base_log + k);
            chk("t4_order", 32'(r.tag), 32'(8'h40 + k));
        end

        // Sustained stream
        base_log = log_q.size();
        t0 = cyc;
        for (int k = 0; k < 20; k++) issue(1'b0, 8'(k), 32'(k * 4), 32'h0);
        chk("t5_req_cycles", 32'(cyc - t0), 32'd20);
        idle(6);
        chk("t5_count", 32'(log_q.size() - base_log), 32'd20);
        for (int k = 0; k < 20; k++) begin
            r = log_at(base_log + k);
            chk("t5_tag", 32'(r.tag), 32'(k));
            chk("t5_no_bubble", 32'(r.cyc - log_at(base_log).cyc), 32'(k));
        end

        // Address wrap, then reset with responses outstanding
        issue(1'b1, 8'h60, 32'(4 * WORDS + 8), 32'h77);
        issue(1'b0, 8'h61, 32'h8, 32'h0);
        idle(6);
        r = log_at(log_q.size() - 1);
        chk("t6_wrap_tag", 32'(r.tag), 32'h61);
        chk("t6_wrap_data", r.data, 32'h77);
        resp_rdy = 1'b0;
        issue(1'b1, 8'h70, 32'h14, 32'hABCD);
        issue(1'b0, 8'h71, 32'h8, 32'h0);
        issue(1'b0, 8'h72, 32'h14, 32'h0);
        idle(2);
        base_rf = dut_resp_fires;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        resp_rdy = 1'b1;
        idle(10);
        chk("t6_no_resp_after_rst", 32'(dut_resp_fires - base_rf), 32'h0);
        chk("t6_word2_persists", dut.read_word(AWB'(2)), 32'h77);
        chk("t6_word5_persists", dut.read_word(AWB'(5)), 32'hABCD);
        issue(1'b0, 8'h62, 32'h14, 32'h0);
        idle(5);
        r = log_at(log_q.size() - 1);
        chk("t6_post_rst_tag", 32'(r.tag), 32'h62);
        chk("t6_post_rst_data", r.data, 32'hABCD);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            a = $urandom();
            a[2 +: AWB] = AWB'($urandom_range(0, 15));
            req_val    = ($urandom_range(0, 3) != 0);
            req_op     = 1'($urandom_range(0, 1));
            req_opaque = 8'($urandom());
            req_addr   = a;
            req_data   = $urandom();
            resp_rdy   = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 149) == 0);
            idle(1);
        end
        rst = 1'b0; req_val = 1'b0; resp_rdy = 1'b1;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
